sram_bus_ctrl: RTL
==================

Name: sram_bus_ctrl

Overview:
- Memory-side stage directly downstream of the processor's memory manager.
- Accepts one read or write request at a time: 15-bit word address, 16-bit data, read/not-write flag.
- Sequences the external asynchronous SRAM strobes with programmable wait states.
- Returns read data with a one-cycle dataIsPresent pulse; the memory manager consumes this pulse to latch the word.

Parameters:
- READ_WAIT, 2, extra cycles oeN is held low beyond the minimum one (0..15).
- WRITE_WAIT, 1, extra cycles weN is held low beyond the minimum one (0..15).
- TURNAROUND, 1, idle cycles with the chip deselected after a read, before the next access (0..15).

Ports:
- clk  in  1  single clock; every state change occurs on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- enable  in  1  request valid; held by the requester until ack.
- rnw  in  1  1 = read, 0 = write; sampled with enable.
- addr  in  15  word address; sampled with enable.
- wdata  in  16  write data; sampled with enable.
- ack  out  1  one-cycle pulse in the cycle after a request is accepted.
- busy  out  1  high whenever state is not IDLE.
- dataIsPresent  out  1  one-cycle pulse; rdata is valid in that cycle.
- done  out  1  one-cycle pulse at the end of every access (read or write).
- rdata  out  16  last read word; holds its value until the next read completes.
- sramAddr  out  15  registered address to the SRAM.
- sramDout  out  16  write data to the SRAM pad driver.
- sramDoe  out  1  pad output enable for sramDout.
- sramDin  in  16  read data from the SRAM pads.
- sramCeN  out  1  chip enable, active low.
- sramOeN  out  1  output enable, active low.
- sramWeN  out  1  write enable, active low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - State → IDLE.
  - sramCeN = sramOeN = sramWeN = 1; sramDoe = 0.
  - ack, busy, dataIsPresent, done = 0.
  - rdata, sramAddr, sramDout = 0.
  - Any access in progress is abandoned; no done pulse is issued.
- States: IDLE, RD, WSETUP, WR, WHOLD, TURN. A 4-bit wait counter is loaded on entry to RD, WR and TURN.
- Accept:
  - Condition: rising edge with state == IDLE and enable == 1.
  - Registers addr → sramAddr, wdata → sramDout, and latches rnw.
  - ack = 1 for the following cycle.
  - enable seen while not in IDLE is ignored; requests are not queued.
  - The requester must deassert enable or present a new request in the cycle after ack. If enable is still high when IDLE is next reached, the request is re-accepted.
- Read path:
  - IDLE → RD. RD lasts READ_WAIT+1 cycles with sramCeN = 0, sramOeN = 0, sramDoe = 0.
  - At the edge ending the last RD cycle: rdata ← sramDin; dataIsPresent = 1 and done = 1 for the next cycle.
  - Next state is TURN if TURNAROUND > 0, otherwise IDLE.
  - TURN: sramCeN = 1 and sramOeN = 1 for TURNAROUND cycles, then IDLE.
- Write path:
  - IDLE → WSETUP: 1 cycle, sramCeN = 0, sramDoe = 1, sramWeN = 1 (address and data settle).
  - WSETUP → WR: WRITE_WAIT+1 cycles with sramWeN = 0.
  - WR → WHOLD: 1 cycle, sramWeN = 1, sramDoe = 1, sramCeN = 0 (data hold).
  - At the edge leaving WHOLD: done = 1 for the next cycle; dataIsPresent stays 0; next state IDLE; sramDoe = 0.
  - No TURN state follows a write.
- sramOeN and sramWeN are never both 0. sramDoe is never 1 while sramOeN = 0.
- Outputs are registered (no combinational path from input to output), except busy, which is decoded from state.
- Latency from the accept edge:
  - Read: rdata valid 2+READ_WAIT cycles later. Next accept possible 2+READ_WAIT+TURNAROUND edges after the accept edge.
  - Write: done 4+WRITE_WAIT cycles later.

Test Plan:
- Reset values: assert resetN = 0 mid-RD → within the same cycle sramCeN/OeN/WeN = 1, sramDoe = 0, busy = 0, no done pulse. Release resetN → IDLE, rdata = 0.
- Read, defaults (READ_WAIT = 2, TURNAROUND = 1): enable = 1, rnw = 1, addr = 15'h1234; model returns 16'hBEEF.
  - ack 1 cycle after the accept edge.
  - sramOeN low for exactly 3 cycles.
  - dataIsPresent and done pulse once; rdata = 16'hBEEF.
  - Next accept is 5 edges after the first.
- Write (WRITE_WAIT = 1): addr = 15'h7FFF, wdata = 16'hA5A5.
  - Sequence: WSETUP 1 cycle, sramWeN low for 2 cycles, WHOLD 1 cycle.
  - Memory model holds 16'hA5A5 at 15'h7FFF.
  - done pulses; dataIsPresent stays 0.
- Back-to-back: enable held high across three requests (read, write, read).
  - Each request is accepted only in IDLE; exactly one ack per accept.
  - No strobe overlap: a checker asserts OeN/WeN exclusivity and Doe/OeN exclusivity every cycle.
- Ignored request: pulse enable for 1 cycle while busy → no ack, no access, state sequence unchanged.
- Parameter corners: READ_WAIT = 0, TURNAROUND = 0 → read completes in 2 cycles with back-to-back accepts. READ_WAIT = 15 → sramOeN low for exactly 16 cycles.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: memory-side stage below the memory manager. Takes one
// read or write request at a time and sequences the strobes of an
// external asynchronous SRAM, with programmable wait states.
//
// Handshake: enable is the request valid. The requester holds it, together
// with rnw/addr/wdata, until it sees ack. A request is taken only on a
// rising edge where the FSM is IDLE. ack pulses for one cycle after that
// edge. Requests seen while busy are dropped, not queued. If enable is still
// high when IDLE is next reached, the request is taken again.
//
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   enable, rnw          request valid, 1 = read / 0 = write
//   addr, wdata          15-bit word address, 16-bit write data
//   ack                  one-cycle pulse after a request is accepted
//   busy                 state != IDLE (decoded, not registered)
//   dataIsPresent        one-cycle pulse, rdata valid in that cycle
//   done                 one-cycle pulse at the end of every access
//   rdata                last word read, held until the next read completes
//   sramAddr, sramDout   registered address and write data to the pads
//   sramDoe              pad output enable for sramDout
//   sramDin              read data from the pads
//   sramCeN/OeN/WeN      active-low chip, output and write enables
module sram_bus_ctrl #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1,
  parameter int TURNAROUND = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic        rnw,
  input  logic [14:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic        busy,
  output logic        dataIsPresent,
  output logic        done,
  output logic [15:0] rdata,
  output logic [14:0] sramAddr,
  output logic [15:0] sramDout,
  output logic        sramDoe,
  input  logic [15:0] sramDin,
  output logic        sramCeN,
  output logic        sramOeN,
  output logic        sramWeN
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WSETUP = 3'd2,
    S_WR     = 3'd3,
    S_WHOLD  = 3'd4,
    S_TURN   = 3'd5
  } state_t;

  // The wait counter counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [3:0] RD_LOAD   = 4'(READ_WAIT);
  localparam logic [3:0] WR_LOAD   = 4'(WRITE_WAIT);
  localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, rd_last, wr_last;
  logic        ack_q, dip_q, done_q;
  logic [15:0] rdata_q, dout_q;
  logic [14:0] addr_q;
  logic        ce_n_q, oe_n_q, we_n_q, doe_q;
  logic        ce_n_d, oe_n_d, we_n_d, doe_d;

  // Next-state logic. The read/write direction is captured by which branch
  // the FSM takes on accept, so rnw needs no separate register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rd_last = 1'b0;
    wr_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          accept = 1'b1;
          if (rnw) begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end else begin
            state_d = S_WSETUP;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          rd_last = 1'b1;
          if (TURNAROUND > 0) begin
            state_d = S_TURN;
            cnt_d   = TURN_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WSETUP: begin
        state_d = S_WR;
        cnt_d   = WR_LOAD;
      end
      S_WR: begin
        if (cnt_q == 4'd0) state_d = S_WHOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WHOLD: begin
        wr_last = 1'b1;
        state_d = S_IDLE;
      end
      S_TURN: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they change
  // on the same edge as the state with no input-to-output path. Because OeN
  // is low only in RD while WeN and Doe are active only in write states,
  // the two enables can never overlap.
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    doe_d  = 1'b0;
    case (state_d)
      S_RD:     begin ce_n_d = 1'b0; oe_n_d = 1'b0; end
      S_WSETUP: begin ce_n_d = 1'b0; doe_d  = 1'b1; end
      S_WR:     begin ce_n_d = 1'b0; doe_d  = 1'b1; we_n_d = 1'b0; end
      S_WHOLD:  begin ce_n_d = 1'b0; doe_d  = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      dip_q   <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 16'd0;
      addr_q  <= 15'd0;
      dout_q  <= 16'd0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= accept;
      dip_q   <= rd_last;
      done_q  <= rd_last | wr_last;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      if (accept) begin
        addr_q <= addr;
        dout_q <= wdata;
      end
      // The pads have been driven for the full read window by this edge.
      if (rd_last) rdata_q <= sramDin;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign ack           = ack_q;
  assign dataIsPresent = dip_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign sramAddr      = addr_q;
  assign sramDout      = dout_q;
  assign sramDoe       = doe_q;
  assign sramCeN       = ce_n_q;
  assign sramOeN       = oe_n_q;
  assign sramWeN       = we_n_q;

endmodule
